free_list: RTL and testbench
============================

# free_list

Physical-register free list for the rename stage. Hands out free physical registers to renaming instructions, takes back each retiring instruction's superseded register (`phy_dst_old`), and reclaims squashed instructions' registers (`phy_dst`) during ROB rewind. It is a circular buffer with two independent insertion points:

- retire frees are appended at the tail;
- rewind returns are pushed back in front of the head, undoing the allocation order.

## Interface
- `PHY_REGS`, 64, number of physical registers; index width `PW = $clog2(PHY_REGS)`.
- `ARC_REGS`, 32, number of architectural registers; index width `AW = $clog2(ARC_REGS)`.
- `ALLOC_WIDTH`, 2, rename lanes per cycle.
- `RETIRE_WIDTH`, 2, retire lanes per cycle.
- `REWIND_WIDTH`, 2, rewind lanes per cycle.
- Clocking: reset reset, synchronous, active-high; clock clock.
- `clock`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `alloc_req`  in  ALLOC_WIDTH  rename lane i needs a destination register (lane 0 is oldest).
- `alloc_valid`  out  ALLOC_WIDTH  lane i granted, combinational in the same cycle.
- `alloc_phy`  out  ALLOC_WIDTH×PW  granted register for lane i; `'0` when not granted.
- `retire_valid`  in  RETIRE_WIDTH  retire lane i valid (lane 0 oldest).
- `retire_arc_dst`  in  RETIRE_WIDTH×AW  architectural destination of retiring instruction.
- `retire_phy_dst_old`  in  RETIRE_WIDTH×PW  register to free.
- `rewind_valid`  in  REWIND_WIDTH  rewind lane i valid (lane 0 youngest).
- `rewind_arc_dst`  in  REWIND_WIDTH×AW  architectural destination of squashed instruction.
- `rewind_phy_dst`  in  REWIND_WIDTH×PW  register to reclaim.
- `free_count`  out  PW+1  registered number of free entries.
- `overflow`  out  1  sticky error flag: an insert would exceed `PHY_REGS` entries.

## Operation
- **Storage:** `mem[PHY_REGS]` of PW bits, plus `head`, `tail` (PW bits, wrap modulo `PHY_REGS`) and `count` (PW+1 bits).
- **Reset state:**
  - `count = PHY_REGS-ARC_REGS`, `head = 0`, `tail = count mod PHY_REGS`;
  - `mem[k] = ARC_REGS+k` for `k < count`, other entries 0;
  - `overflow = 0`; all `alloc_valid = 0` while reset is high.
- **x0 filter:** a retire or rewind lane with `arc_dst == 0` is treated as invalid (x0 never owns a freeable register).
- **Rewind (cycle has any effective rewind lane):**
  - Effective lanes, compacted in lane order, write `mem[head-1]`, `mem[head-2]`, …
  - `head -= n_rew`.
  - All `alloc_valid` are forced to 0 that cycle.
  - Because lanes arrive youngest-first, the original allocation order is restored exactly.
- **Retire:** effective lanes, compacted in lane order, write `mem[tail]`, `mem[tail+1]`, …; then `tail += n_ret`.
- **Allocate (no rewind this cycle):**
  - Lane i is granted iff `alloc_req[i]`, all lower requesting lanes are granted, and (number granted so far) < `count`. Strictly in-order: a denied lane denies all higher lanes.
  - Granted lane j, in grant order, receives `mem[head+j]`.
  - `head += n_alloc`.
- **Count update:** `count_next = count + n_rew + n_ret - n_alloc`.
  - Allocation sees only the registered `count` and `mem`. There is no same-cycle bypass of freed or rewound registers.
- **Overflow:** if `count + n_rew + n_ret - n_alloc > PHY_REGS`, set `overflow` (sticky until reset) and drop the excess inserts. State otherwise stays consistent.
- **Simultaneous events:** rewind and retire in the same cycle are both applied; they touch disjoint ends of the buffer.

## Timing
- `alloc_valid` / `alloc_phy`: combinational from `alloc_req`, `rewind_valid` and registered state, with zero latency.
- Inserted registers become allocatable in the cycle after insertion.
- `free_count` and `overflow` are registered and reflect the previous edge's update.
- Wrap-around: all pointer arithmetic is modulo `PHY_REGS`; `head-1` from 0 yields `PHY_REGS-1`.
- **Empty** (`count == 0`): all grants are 0; rename stalls until a retire or rewind lands.
- **Full** (`count == PHY_REGS`): any further effective insert raises `overflow`.
- **Reset mid-operation:** all state returns to the reset state on the next edge; in-flight grants are discarded.

## Test plan
- **Reset contents:** after reset, single-lane requests for 32 cycles -> grants 32, 33, …, 63 in order, `free_count` decrements to 0, then `alloc_valid = 0`.
- **Dual alloc at boundary:** `count = 1` and `alloc_req = 2'b11` -> only lane 0 granted; lane 1 denied.
- **Retire frees:** retire `arc_dst = 5`, `phy_dst_old = 7` while empty -> `alloc_valid = 0` that cycle; next cycle, a request is granted phy 7.
- **Rewind restores order:**
  - From reset, allocate 32, 33, 34.
  - Rewind youngest-first {34, 33} in one cycle -> `alloc_req` is ignored that cycle.
  - The next two grants are 33, then 34; `free_count` returns to 31.
- **x0 filter:** retire with `arc_dst = 0`, `phy_dst_old = 9` -> `free_count` unchanged and 9 is never granted.
- **Overflow:** from reset, retire two distinct registers (`arc_dst ≠ 0`) per cycle for 17 cycles -> `overflow` rises and stays 1 until reset.

Source files
------------

// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list: tail inserts on retire, head push-back on rewind
// Circular buffer; pointer wrap relies on PHY_REGS being a power of two.
module free_list #(
  parameter int PHY_REGS     = 64,
  parameter int ARC_REGS     = 32,
  parameter int ALLOC_WIDTH  = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int REWIND_WIDTH = 2,
  localparam int PW = $clog2(PHY_REGS),
  localparam int AW = $clog2(ARC_REGS)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [ALLOC_WIDTH-1:0]              alloc_req,
  output logic [ALLOC_WIDTH-1:0]              alloc_valid,
  output logic [ALLOC_WIDTH-1:0][PW-1:0]      alloc_phy,
  input  logic [RETIRE_WIDTH-1:0]             retire_valid,
  input  logic [RETIRE_WIDTH-1:0][AW-1:0]     retire_arc_dst,
  input  logic [RETIRE_WIDTH-1:0][PW-1:0]     retire_phy_dst_old,
  input  logic [REWIND_WIDTH-1:0]             rewind_valid,
  input  logic [REWIND_WIDTH-1:0][AW-1:0]     rewind_arc_dst,
  input  logic [REWIND_WIDTH-1:0][PW-1:0]     rewind_phy_dst,
  output logic [PW:0]                         free_count,
  output logic                                overflow
);

  localparam int CW = PW + 2;
  localparam int INIT_COUNT = PHY_REGS - ARC_REGS;

  logic [PW-1:0] mem [PHY_REGS];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  logic          rewinding, blocked, overflow_hit;
  logic [PW:0]   n_alloc, n_rew, n_ret, count_next;
  logic [CW-1:0] room;
  logic [PW-1:0] head_next;
  logic [REWIND_WIDTH-1:0]          rew_we;
  logic [REWIND_WIDTH-1:0][PW-1:0]  rew_idx, rew_data;
  logic [RETIRE_WIDTH-1:0]          ret_we;
  logic [RETIRE_WIDTH-1:0][PW-1:0]  ret_idx, ret_data;

  assign free_count = count;

  always_comb begin
    rewinding = 1'b0;
    for (int i = 0; i < REWIND_WIDTH; i++)
      if (rewind_valid[i] && rewind_arc_dst[i] != '0) rewinding = 1'b1;

    // In-order grant: the first denied requester blocks every higher lane.
    alloc_valid = '0;
    alloc_phy   = '0;
    n_alloc     = '0;
    blocked     = 1'b0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      if (alloc_req[i] && !blocked) begin
        if (!reset && !rewinding && n_alloc < count) begin
          alloc_valid[i] = 1'b1;
          alloc_phy[i]   = mem[head + n_alloc[PW-1:0]];
          n_alloc        = n_alloc + (PW+1)'(1);
        end else begin
          blocked = 1'b1;
        end
      end
    end

    // Inserts beyond the free slots are dropped; rewind lanes claim room first.
    room         = CW'(PHY_REGS) - {1'b0, count} + {1'b0, n_alloc};
    overflow_hit = 1'b0;
    n_rew        = '0;
    rew_we       = '0;
    rew_idx      = '0;
    rew_data     = '0;
    for (int i = 0; i < REWIND_WIDTH; i++) begin
      if (rewind_valid[i] && rewind_arc_dst[i] != '0) begin
        if ({1'b0, n_rew} < room) begin
          rew_we[i]   = 1'b1;
          rew_idx[i]  = head - PW'(1) - n_rew[PW-1:0];
          rew_data[i] = rewind_phy_dst[i];
          n_rew       = n_rew + (PW+1)'(1);
        end else begin
          overflow_hit = 1'b1;
        end
      end
    end

    n_ret    = '0;
    ret_we   = '0;
    ret_idx  = '0;
    ret_data = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (retire_valid[i] && retire_arc_dst[i] != '0) begin
        if ({1'b0, n_rew + n_ret} < room) begin
          ret_we[i]   = 1'b1;
          ret_idx[i]  = tail + n_ret[PW-1:0];
          ret_data[i] = retire_phy_dst_old[i];
          n_ret       = n_ret + (PW+1)'(1);
        end else begin
          overflow_hit = 1'b1;
        end
      end
    end

    count_next = count + n_rew + n_ret - n_alloc;
    head_next  = rewinding ? head - n_rew[PW-1:0] : head + n_alloc[PW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= PW'(INIT_COUNT);
      count    <= (PW+1)'(INIT_COUNT);
      overflow <= 1'b0;
      for (int k = 0; k < PHY_REGS; k++)
        mem[k] <= (k < INIT_COUNT) ? PW'(ARC_REGS + k) : '0;
    end else begin
      head  <= head_next;
      tail  <= tail + n_ret[PW-1:0];
      count <= count_next;
      if (overflow_hit) overflow <= 1'b1;
      for (int i = 0; i < REWIND_WIDTH; i++)
        if (rew_we[i]) mem[rew_idx[i]] <= rew_data[i];
      for (int i = 0; i < RETIRE_WIDTH; i++)
        if (ret_we[i]) mem[ret_idx[i]] <= ret_data[i];
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list
// Expected grants are queued when requests are driven and popped at the following negedge.
module tb_free_list;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_valid;
  logic [1:0][5:0]  alloc_phy;
  logic [1:0]       retire_valid;
  logic [1:0][4:0]  retire_arc_dst;
  logic [1:0][5:0]  retire_phy_dst_old;
  logic [1:0]       rewind_valid;
  logic [1:0][4:0]  rewind_arc_dst;
  logic [1:0][5:0]  rewind_phy_dst;
  logic [6:0]       free_count;
  logic             overflow;

  typedef struct packed {
    logic       v;
    logic [5:0] p;
  } grant_t;

  grant_t exp_q[$];
  int total = 0;
  int bad   = 0;

  free_list dut (
    .clock              (clock),
    .reset              (reset),
    .alloc_req          (alloc_req),
    .alloc_valid        (alloc_valid),
    .alloc_phy          (alloc_phy),
    .retire_valid       (retire_valid),
    .retire_arc_dst     (retire_arc_dst),
    .retire_phy_dst_old (retire_phy_dst_old),
    .rewind_valid       (rewind_valid),
    .rewind_arc_dst     (rewind_arc_dst),
    .rewind_phy_dst     (rewind_phy_dst),
    .free_count         (free_count),
    .overflow           (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc_req          = '0;
    retire_valid       = '0;
    retire_arc_dst     = '0;
    retire_phy_dst_old = '0;
    rewind_valid       = '0;
    rewind_arc_dst     = '0;
    rewind_phy_dst     = '0;
  endtask

  task automatic drive_alloc(input logic [1:0] req, input logic v0, input logic [5:0] p0,
                             input logic v1, input logic [5:0] p1);
    grant_t g;
    alloc_req = req;
    g.v = v0; g.p = v0 ? p0 : 6'd0; exp_q.push_back(g);
    g.v = v1; g.p = v1 ? p1 : 6'd0; exp_q.push_back(g);
  endtask

  task automatic tick();
    grant_t g;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        g = exp_q.pop_front();
        check($sformatf("alloc_valid%0d", i), 32'(alloc_valid[i]), 32'(g.v));
        check($sformatf("alloc_phy%0d", i), 32'(alloc_phy[i]), 32'(g.p));
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    drive_alloc(2'b11, 0, 0, 0, 0);
    tick();
    check("rst_count", 32'(free_count), 32'd32);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // drain initial contents one lane at a time
    for (int k = 0; k < 32; k++) begin
      drive_alloc(2'b01, 1, 6'(32 + k), 0, 0);
      tick();
      check("drain_count", 32'(free_count), 32'(31 - k));
    end
    drive_alloc(2'b11, 0, 0, 0, 0);
    tick();

    // retire while empty: not visible until next cycle
    retire_valid = 2'b01; retire_arc_dst[0] = 5'd5; retire_phy_dst_old[0] = 6'd7;
    drive_alloc(2'b01, 0, 0, 0, 0);
    tick();
    clear_inputs();
    check("retire_count", 32'(free_count), 32'd1);
    drive_alloc(2'b01, 1, 6'd7, 0, 0);
    tick();

    // count == 1 with dual request
    retire_valid = 2'b01; retire_arc_dst[0] = 5'd3; retire_phy_dst_old[0] = 6'd8;
    drive_alloc(2'b00, 0, 0, 0, 0);
    tick();
    clear_inputs();
    drive_alloc(2'b11, 1, 6'd8, 0, 0);
    tick();
    check("dual_count", 32'(free_count), 32'd0);

    // x0 retire is ignored
    retire_valid = 2'b01; retire_arc_dst[0] = 5'd0; retire_phy_dst_old[0] = 6'd9;
    drive_alloc(2'b00, 0, 0, 0, 0);
    tick();
    clear_inputs();
    check("x0_count", 32'(free_count), 32'd0);
    drive_alloc(2'b01, 0, 0, 0, 0);
    tick();

    // reset mid-operation, then rewind restores allocation order
    reset = 1'b1;
    drive_alloc(2'b11, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    check("rst2_count", 32'(free_count), 32'd32);
    drive_alloc(2'b11, 1, 6'd32, 1, 6'd33);
    tick();
    drive_alloc(2'b01, 1, 6'd34, 0, 0);
    tick();
    check("alloc3_count", 32'(free_count), 32'd29);
    rewind_valid = 2'b11;
    rewind_arc_dst[0] = 5'd4; rewind_phy_dst[0] = 6'd34;
    rewind_arc_dst[1] = 5'd3; rewind_phy_dst[1] = 6'd33;
    drive_alloc(2'b11, 0, 0, 0, 0);
    tick();
    clear_inputs();
    check("rewind_count", 32'(free_count), 32'd31);
    drive_alloc(2'b01, 1, 6'd33, 0, 0);
    tick();
    drive_alloc(2'b01, 1, 6'd34, 0, 0);
    tick();
    check("realloc_count", 32'(free_count), 32'd29);

    // rewind and retire together
    rewind_valid = 2'b01; rewind_arc_dst[0] = 5'd4; rewind_phy_dst[0] = 6'd34;
    retire_valid = 2'b01; retire_arc_dst[0] = 5'd2; retire_phy_dst_old[0] = 6'd20;
    drive_alloc(2'b11, 0, 0, 0, 0);
    tick();
    clear_inputs();
    check("both_count", 32'(free_count), 32'd31);
    drive_alloc(2'b11, 1, 6'd34, 1, 6'd35);
    tick();
    check("both_alloc_count", 32'(free_count), 32'd29);

    // overflow: fill past PHY_REGS with dual retires
    reset = 1'b1;
    drive_alloc(2'b00, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      retire_valid = 2'b11;
      retire_arc_dst[0] = 5'd1; retire_phy_dst_old[0] = 6'(2 * k);
      retire_arc_dst[1] = 5'd2; retire_phy_dst_old[1] = 6'(2 * k + 1);
      drive_alloc(2'b00, 0, 0, 0, 0);
      tick();
      check("ovf_flag", 32'(overflow), (k == 16) ? 32'd1 : 32'd0);
      check("ovf_count", 32'(free_count), (k >= 15) ? 32'd64 : 32'(32 + 2 * (k + 1)));
    end
    clear_inputs();
    drive_alloc(2'b01, 1, 6'd32, 0, 0);
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_alloc_count", 32'(free_count), 32'd63);
    reset = 1'b1;
    drive_alloc(2'b00, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
